tx_frame_scheduler: RTL and testbench

//  Round-robin scheduler sharing one TxTop UART transmitter among 4 byte requesters.
//  Per grant it latches one byte and its frame config and drives TxTop in_data/para/s_num/d_num/bd_rate.
//  It pulses start and times the whole frame from clk. The next grant comes only after frame + guard gap.

---
 rtl/tx_frame_scheduler.sv | 268 ++++++++++++++++++++++++++
 tb/tb_tx_frame_scheduler.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/tx_frame_scheduler.sv
// Round-robin scheduler sharing one TxTop UART transmitter among 4 byte requesters.
// Optional macro TXSCHED_PRIO0_EN gives requester 0 fixed top priority over the rotating others.
module tx_frame_scheduler #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int GAP_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    input  logic [23:0] req_cfg,
    output logic [3:0]  ack,
    output logic [7:0]  tx_data,
    output logic [1:0]  tx_para,
    output logic        tx_s_num,
    output logic        tx_d_num,
    output logic [1:0]  tx_bd_rate,
    output logic        tx_start,
    output logic        busy,
    output logic [1:0]  grant_id,
    output logic        frame_done
);

    localparam int DIV_MAX = CLK_HZ / 1200;
    localparam int CNT_W   = $clog2(DIV_MAX * 12) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] div_of(input logic [1:0] rate);
        case (rate)
            2'd0:    div_of = CNT_W'(CLK_HZ / 1200);
            2'd1:    div_of = CNT_W'(CLK_HZ / 2400);
            2'd2:    div_of = CNT_W'(CLK_HZ / 4800);
            default: div_of = CNT_W'(CLK_HZ / 9600);
        endcase
    endfunction

    // Start + data + optional parity + stop bits; para=11 carries no parity bit.
    function automatic logic [3:0] nbits_of(input logic [1:0] para, input logic s_num,
                                            input logic d_num);
        logic [3:0] par_bit;
        par_bit = ((para == 2'b01) || (para == 2'b10)) ? 4'd1 : 4'd0;
        nbits_of = 4'd1 + (d_num ? 4'd8 : 4'd7) + par_bit + (s_num ? 4'd2 : 4'd1);
    endfunction

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [3:0]        bit_q, bit_d;
    logic [CNT_W-1:0]  div_q, div_d;
    logic [3:0]        nbits_q, nbits_d;
    logic [1:0]        ptr_q, ptr_d;

    logic [3:0]        ack_q, ack_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [1:0]        tx_para_q, tx_para_d;
    logic              tx_s_num_q, tx_s_num_d;
    logic              tx_d_num_q, tx_d_num_d;
    logic [1:0]        tx_bd_rate_q, tx_bd_rate_d;
    logic              tx_start_q, tx_start_d;
    logic              busy_q, busy_d;
    logic [1:0]        grant_q, grant_d;
    logic              frame_done_q, frame_done_d;

    logic              found_s;
    logic [1:0]        win_s;
    logic [7:0]        win_data_s;
    logic [5:0]        win_cfg_s;
    logic              last_cyc_s;

    // Arbiter: lowest rotated offset from ptr wins (descending scan, last write wins).
    always_comb begin
        found_s = |req;
        win_s   = 2'd0;
`ifdef TXSCHED_PRIO0_EN
        if (req[0]) begin
            win_s = 2'd0;
        end else begin
            for (int k = 3; k >= 0; k--) begin
                if (req[ptr_q + 2'(k)] && ((ptr_q + 2'(k)) != 2'd0)) begin
                    win_s = ptr_q + 2'(k);
                end else begin
                    win_s = win_s;
                end
            end
        end
`else
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr_q + 2'(k)]) begin
                win_s = ptr_q + 2'(k);
            end else begin
                win_s = win_s;
            end
        end
`endif
    end

    // Winner byte/config mux.
    always_comb begin
        case (win_s)
            2'd0:    begin win_data_s = req_data[7:0];   win_cfg_s = req_cfg[5:0];   end
            2'd1:    begin win_data_s = req_data[15:8];  win_cfg_s = req_cfg[11:6];  end
            2'd2:    begin win_data_s = req_data[23:16]; win_cfg_s = req_cfg[17:12]; end
            default: begin win_data_s = req_data[31:24]; win_cfg_s = req_cfg[23:18]; end
        endcase
    end

    // FSM state and frame counters register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            bit_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
        end
    end

    assign last_cyc_s = (cyc_q == (div_q - CNT_W'(1)));

    // Next-state logic: cycle counter wraps every DIV, bit counter steps per wrap.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        case (state_q)
            S_IDLE: begin
                cyc_d = '0;
                bit_d = 4'd0;
                if (found_s) state_d = S_LOAD;
                else         state_d = S_IDLE;
            end
            S_LOAD: begin
                state_d = S_SEND;
                cyc_d   = '0;
                bit_d   = 4'd0;
            end
            S_SEND: begin
                if (last_cyc_s) begin
                    cyc_d = '0;
                    if (bit_q == (nbits_q - 4'd1)) begin
                        state_d = S_GAP;
                        bit_d   = 4'd0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cyc_d = cyc_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (last_cyc_s) begin
                    cyc_d = '0;
                    if (bit_q == 4'(GAP_BITS - 1)) begin
                        state_d = S_IDLE;
                        bit_d   = 4'd0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cyc_d = cyc_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = '0;
                bit_d   = 4'd0;
            end
        endcase
    end

    // Output/datapath next values; outputs are derived from the next state so they register cleanly.
    always_comb begin
        ack_d        = 4'd0;
        tx_data_d    = tx_data_q;
        tx_para_d    = tx_para_q;
        tx_s_num_d   = tx_s_num_q;
        tx_d_num_d   = tx_d_num_q;
        tx_bd_rate_d = tx_bd_rate_q;
        grant_d      = grant_q;
        ptr_d        = ptr_q;
        div_d        = div_q;
        nbits_d      = nbits_q;
        case (state_q)
            S_IDLE: begin
                if (found_s) begin
                    ack_d        = 4'b0001 << win_s;
                    grant_d      = win_s;
                    tx_data_d    = win_data_s;
                    tx_bd_rate_d = win_cfg_s[5:4];
                    tx_para_d    = win_cfg_s[3:2];
                    tx_s_num_d   = win_cfg_s[1];
                    tx_d_num_d   = win_cfg_s[0];
`ifdef TXSCHED_PRIO0_EN
                    if (win_s != 2'd0) ptr_d = win_s + 2'd1;
                    else               ptr_d = ptr_q;
`else
                    ptr_d = win_s + 2'd1;
`endif
                end else begin
                    ack_d = 4'd0;
                end
            end
            S_LOAD: begin
                div_d   = div_of(tx_bd_rate_q);
                nbits_d = nbits_of(tx_para_q, tx_s_num_q, tx_d_num_q);
            end
            default: begin
                ack_d = 4'd0;
            end
        endcase
        tx_start_d   = (state_d == S_SEND) && (bit_d == 4'd0);
        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_d == S_GAP) && (cyc_d == (div_q - CNT_W'(1)))
                       && (bit_d == 4'(GAP_BITS - 1));
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q        <= 4'd0;
            tx_data_q    <= 8'd0;
            tx_para_q    <= 2'd0;
            tx_s_num_q   <= 1'b0;
            tx_d_num_q   <= 1'b0;
            tx_bd_rate_q <= 2'd0;
            tx_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            grant_q      <= 2'd0;
            frame_done_q <= 1'b0;
            ptr_q        <= 2'd0;
            div_q        <= CNT_W'(1);
            nbits_q      <= 4'd1;
        end else begin
            ack_q        <= ack_d;
            tx_data_q    <= tx_data_d;
            tx_para_q    <= tx_para_d;
            tx_s_num_q   <= tx_s_num_d;
            tx_d_num_q   <= tx_d_num_d;
            tx_bd_rate_q <= tx_bd_rate_d;
            tx_start_q   <= tx_start_d;
            busy_q       <= busy_d;
            grant_q      <= grant_d;
            frame_done_q <= frame_done_d;
            ptr_q        <= ptr_d;
            div_q        <= div_d;
            nbits_q      <= nbits_d;
        end
    end

    assign ack        = ack_q;
    assign tx_data    = tx_data_q;
    assign tx_para    = tx_para_q;
    assign tx_s_num   = tx_s_num_q;
    assign tx_d_num   = tx_d_num_q;
    assign tx_bd_rate = tx_bd_rate_q;
    assign tx_start   = tx_start_q;
    assign busy       = busy_q;
    assign grant_id   = grant_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed self-checking bench for tx_frame_scheduler at CLK_HZ=96_000 (DIV 80/40/20/10).
module tb_tx_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [23:0] req_cfg;
    logic [3:0]  ack;
    logic [7:0]  tx_data;
    logic [1:0]  tx_para;
    logic        tx_s_num;
    logic        tx_d_num;
    logic [1:0]  tx_bd_rate;
    logic        tx_start;
    logic        busy;
    logic [1:0]  grant_id;
    logic        frame_done;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    tx_frame_scheduler #(.CLK_HZ(96_000), .GAP_BITS(2)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_cfg(req_cfg),
        .ack(ack), .tx_data(tx_data), .tx_para(tx_para), .tx_s_num(tx_s_num),
        .tx_d_num(tx_d_num), .tx_bd_rate(tx_bd_rate), .tx_start(tx_start),
        .busy(busy), .grant_id(grant_id), .frame_done(frame_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Steps until an ack appears (bounded); returns the observed ack, 0 on timeout.
    task automatic wait_ack(output logic [3:0] a);
        int n;
        n = 0;
        step();
        while (ack == 4'd0 && n < 50) begin
            step();
            n++;
        end
        a = ack;
    endtask

    // From the LOAD cycle: counts tx_start cycles and cycles until frame_done, inclusive.
    task automatic measure(input string tag, input int exp_start, input int exp_total);
        int ns;
        int nt;
        ns = 0;
        nt = 0;
        step();
        check({tag, "_start_lat"}, tx_start, 1);
        while (nt < 4000) begin
            if (tx_start) ns++;
            nt++;
            if (frame_done) break;
            step();
        end
        check({tag, "_start_len"}, ns, exp_start);
        check({tag, "_frame_len"}, nt, exp_total);
        step();
        check({tag, "_idle_after"}, {busy, frame_done}, 0);
    endtask

    initial begin
        logic [3:0] a;
        logic [1:0] order [5];
        logic [7:0] bytes [4];

        rst = 1'b1; req = 4'd0; req_data = 32'd0; req_cfg = 24'd0;

        // 1: reset state
        step(); step(); step();
        check("reset_outputs", {ack, tx_data, tx_para, tx_s_num, tx_d_num, tx_bd_rate,
                                tx_start, busy, grant_id, frame_done}, 0);
        rst = 1'b0;
        step(); step(); step();
        check("idle_no_req", busy, 0);

        // 2: requester 0, 1200 7N1 -> 9*80 + 2*80
        req_data[7:0] = 8'h2D; req_cfg[5:0] = 6'b000000; req = 4'b0001;
        wait_ack(a);
        check("t2_ack", a, 4'b0001);
        check("t2_data", tx_data, 8'h2D);
        check("t2_grant", grant_id, 0);
        check("t2_load_busy", {busy, tx_start}, 2'b10);
        req = 4'd0;
        measure("t2", 80, 880);

        // 3: requester 1, 2400 odd 2-stop 8-bit -> 12*40 + 2*40; cfg change after ack ignored
        req_data[15:8] = 8'h5A; req_cfg[11:6] = 6'b010111; req = 4'b0010;
        wait_ack(a);
        check("t3_ack", a, 4'b0010);
        check("t3_cfg", {tx_bd_rate, tx_para, tx_s_num, tx_d_num}, 6'b010111);
        req = 4'd0; req_cfg[11:6] = 6'b000000;
        measure("t3", 40, 560);
        check("t3_hold", {tx_data, tx_bd_rate, tx_para, tx_s_num, tx_d_num}, {8'h5A, 6'b010111});

        // 3b: requester 0, 4800 para=11 (no parity bit) 2-stop 7-bit -> 10*20 + 2*20
        req_data[7:0] = 8'hC3; req_cfg[5:0] = 6'b101110; req = 4'b0001;
        wait_ack(a);
        check("t3b_ack", a, 4'b0001);
        check("t3b_para", tx_para, 2'b11);
        req = 4'd0;
        measure("t3b", 20, 240);

        // 5: reset 50 cycles into SEND abandons the frame
        req_data[23:16] = 8'h77; req_cfg[17:12] = 6'b000001; req = 4'b0100;
        wait_ack(a);
        check("t5_ack", a, 4'b0100);
        check("t5_grant", grant_id, 2);
        req = 4'd0;
        for (int i = 0; i < 50; i++) step();
        check("t5_mid_send", tx_start, 1);
        rst = 1'b1;
        step();
        check("t5_after_rst", {tx_start, busy, tx_data, ack, grant_id, frame_done}, 0);
        rst = 1'b0;

        // 4/6: all requesters held, 9600 8N1 -> 10*10 + 2*10
        req_data = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        req_cfg  = {4{6'b110001}};
        bytes[0] = 8'hA1; bytes[1] = 8'hB2; bytes[2] = 8'hC3; bytes[3] = 8'hD4;
`ifdef TXSCHED_PRIO0_EN
        order[0] = 2'd0; order[1] = 2'd0; order[2] = 2'd0; order[3] = 2'd0; order[4] = 2'd0;
`else
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
`endif
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack(a);
            check($sformatf("t4_ack%0d", k), a, 4'b0001 << order[k]);
            check($sformatf("t4_grant%0d", k), grant_id, order[k]);
            check($sformatf("t4_data%0d", k), tx_data, bytes[order[k]]);
            measure($sformatf("t4_f%0d", k), 10, 120);
        end
        req = 4'd0;
        step(); step(); step();
        check("t4_drain", {busy, ack}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
